mc_seq_ctrl: RTL and testbench

MC_SEQ_CTRL -- requirements
Module: mc_seq_ctrl

---
 rtl/mc_pkg.sv | 17 +
 rtl/mc_seq_ctrl_if.sv | 35 +++
 rtl/mc_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mc_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and
// default parameter values.
package mc_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
    localparam int          CNT_W_DEF    = 32;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Fetch and data buses between the sequencer (master) and its memories (slave).
// Handshake: req is held with addr/wdata/we stable until ack is high; the cycle with
// req and ack both high completes the transfer, and rdata is valid only in that cycle.
interface mc_seq_ctrl_if
    import mc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            inst_req;
    logic [XLEN-1:0] inst_addr;
    logic            inst_ack;
    logic [31:0]     inst_rdata;

    logic            data_req;
    logic            data_we;
    logic [XLEN-1:0] data_addr;
    logic [XLEN-1:0] data_wdata;
    logic            data_ack;
    logic [XLEN-1:0] data_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_ack, inst_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_ack, data_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_ack, inst_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_ack, data_rdata
    );

endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer: fetches, steps an external decoder/ALU
// through the stages, drives the data bus and register-file write, and retires.
module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic             inst_req,
    output logic [XLEN-1:0]  inst_addr,
    input  logic             inst_ack,
    input  logic [31:0]      inst_rdata,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  pc,
    input  logic             dec_is_jump,
    input  logic             dec_is_load,
    input  logic             dec_is_store,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  store_data,
    output logic             data_req,
    output logic             data_we,
    output logic [XLEN-1:0]  data_addr,
    output logic [XLEN-1:0]  data_wdata,
    input  logic             data_ack,
    input  logic [XLEN-1:0]  data_rdata,
    output logic             rf_we,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [31:0]       ir_q;
    logic [XLEN-1:0]   res_q;
    logic [XLEN-1:0]   sd_q;
    logic [XLEN-1:0]   tgt_q;
    logic              br_q;
    logic              st_q;
    logic [CNT_W-1:0]  retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            res_q     <= '0;
            sd_q      <= '0;
            tgt_q     <= '0;
            br_q      <= 1'b0;
            st_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_IF: begin
                    if (inst_ack) begin
                        ir_q    <= inst_rdata;
                        state_q <= S_ID;
                    end
                end
                S_ID: begin
                    br_q  <= br_taken;
                    tgt_q <= br_target;
                    // A jump retires here, so it redirects from the live decision, not br_q.
                    if (dec_is_jump) begin
                        pc_q      <= br_taken ? br_target : pc_q + XLEN'(4);
                        retired_q <= retired_q + CNT_W'(1);
                        state_q   <= S_IF;
                    end else begin
                        state_q <= S_EXE;
                    end
                end
                S_EXE: begin
                    res_q   <= alu_result;
                    sd_q    <= store_data;
                    st_q    <= dec_is_store;
                    state_q <= (dec_is_load || dec_is_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (data_ack) begin
                        if (st_q) begin
                            pc_q      <= br_q ? tgt_q : pc_q + XLEN'(4);
                            retired_q <= retired_q + CNT_W'(1);
                            state_q   <= S_IF;
                        end else begin
                            res_q   <= data_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc_q      <= br_q ? tgt_q : pc_q + XLEN'(4);
                    retired_q <= retired_q + CNT_W'(1);
                    state_q   <= S_IF;
                end
                default: state_q <= S_IF;
            endcase
        end
    end

    // Strobes decode the state and are masked by reset so a request drops in the reset cycle itself.
    assign inst_req   = !reset && (state_q == S_IF);
    assign data_req   = !reset && (state_q == S_MEM);
    assign data_we    = data_req && st_q;
    assign rf_we      = !reset && (state_q == S_WB);

    assign inst_addr  = pc_q;
    assign data_addr  = res_q;
    assign data_wdata = sd_q;
    assign rf_wdata   = res_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: steps instructions through the sequencer with a
// scoreboard of expected register writes and stores.
module tb_mc_seq_ctrl;
    import mc_pkg::*;

    localparam int          XLEN   = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam int K_ALU = 0, K_JMP = 1, K_LD = 2, K_ST = 3;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    logic [31:0]      ir;
    logic [XLEN-1:0]  pc;
    logic             dec_is_jump, dec_is_load, dec_is_store;
    logic             br_taken;
    logic [XLEN-1:0]  br_target, alu_result, store_data;
    logic             rf_we;
    logic [XLEN-1:0]  rf_wdata;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    mc_seq_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (bus.inst_req),
        .inst_addr    (bus.inst_addr),
        .inst_ack     (bus.inst_ack),
        .inst_rdata   (bus.inst_rdata),
        .ir           (ir),
        .pc           (pc),
        .dec_is_jump  (dec_is_jump),
        .dec_is_load  (dec_is_load),
        .dec_is_store (dec_is_store),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .data_req     (bus.data_req),
        .data_we      (bus.data_we),
        .data_addr    (bus.data_addr),
        .data_wdata   (bus.data_wdata),
        .data_ack     (bus.data_ack),
        .data_rdata   (bus.data_rdata),
        .rf_we        (rf_we),
        .rf_wdata     (rf_wdata),
        .state        (state),
        .retired      (retired)
    );

    // scoreboard
    logic [XLEN-1:0]   exp_q[$];
    logic [2*XLEN-1:0] st_exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_pc;
    int m_ret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("req_exclusive", 64'(bus.inst_req & bus.data_req), 64'd0);
        if (rf_we === 1'b1) begin
            check("rf_we_expected", 64'(rf_we), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("rf_wdata", 64'(rf_wdata), 64'(exp_q.pop_front()));
        end
        if (bus.data_req && bus.data_ack && bus.data_we) begin
            check("store_expected", 64'(bus.data_we), 64'(st_exp_q.size() != 0));
            if (st_exp_q.size() != 0)
                check("store_addr_data", {bus.data_addr, bus.data_wdata}, st_exp_q.pop_front());
        end
    end

    // driver: one instruction from IF to retire; entered and left just after a rising edge in IF
    task automatic run_instr(input int kind, input bit taken, input logic [31:0] target,
                             input logic [31:0] alu, input logic [31:0] sdat, input logic [31:0] ldat,
                             input int iwait, input int dwait, input bit stray, input bit rst_mid);
        logic [31:0] word;
        word = $urandom;
        bus.inst_ack = 1'b0;
        for (int i = 0; i < iwait; i++) begin
            @(negedge clk);
            check("if_wait_req", 64'(bus.inst_req), 64'd1);
            check("if_wait_addr", 64'(bus.inst_addr), 64'(m_pc));
            @(posedge clk); #1;
        end
        bus.inst_ack = 1'b1;
        bus.inst_rdata = word;
        @(negedge clk);
        check("if_state", 64'(state), 64'(S_IF));
        check("if_req", 64'(bus.inst_req), 64'd1);
        check("if_addr", 64'(bus.inst_addr), 64'(m_pc));
        check("if_no_dreq", 64'(bus.data_req), 64'd0);
        @(posedge clk); #1;
        bus.inst_ack = 1'b0;
        bus.inst_rdata = $urandom;
        dec_is_jump  = (kind == K_JMP);
        dec_is_load  = (kind == K_LD);
        dec_is_store = (kind == K_ST);
        br_taken  = taken;
        br_target = target;
        @(negedge clk);
        check("id_state", 64'(state), 64'(S_ID));
        check("id_ir", 64'(ir), 64'(word));
        check("id_no_ireq", 64'(bus.inst_req), 64'd0);
        @(posedge clk); #1;
        br_taken  = 1'($urandom_range(0, 1));
        br_target = $urandom;
        if (kind != K_JMP) begin
            alu_result = alu;
            store_data = sdat;
            if (stray) begin
                bus.inst_ack = 1'b1;
                bus.inst_rdata = ~word;
            end
            if (kind == K_ALU) exp_q.push_back(alu);
            else if (kind == K_LD) exp_q.push_back(ldat);
            else if (!rst_mid) st_exp_q.push_back({alu, sdat});
            @(negedge clk);
            check("exe_state", 64'(state), 64'(S_EXE));
            check("exe_pc_hold", 64'(pc), 64'(m_pc));
            @(posedge clk); #1;
            bus.inst_ack = 1'b0;
            alu_result = $urandom;
            store_data = $urandom;
            if (kind == K_LD || kind == K_ST) begin
                if (rst_mid) begin
                    @(negedge clk);
                    check("rm_mem_req", 64'(bus.data_req), 64'd1);
                    @(posedge clk); #1;
                    reset = 1'b1;
                    @(negedge clk);
                    check("rm_dreq_drop", 64'(bus.data_req), 64'd0);
                    check("rm_dwe_drop", 64'(bus.data_we), 64'd0);
                    check("rm_ireq_low", 64'(bus.inst_req), 64'd0);
                    @(posedge clk); #1;
                    reset = 1'b0;
                    bus.data_ack = 1'b1;
                    bus.data_rdata = $urandom;
                    m_pc = RST_PC;
                    m_ret = 0;
                    @(negedge clk);
                    check("rm_state", 64'(state), 64'(S_IF));
                    check("rm_pc", 64'(pc), 64'(RST_PC));
                    check("rm_retired", 64'(retired), 64'd0);
                    check("rm_ireq", 64'(bus.inst_req), 64'd1);
                    check("rm_late_dreq", 64'(bus.data_req), 64'd0);
                    @(posedge clk); #1;
                    bus.data_ack = 1'b0;
                    @(negedge clk);
                    check("rm_late_ack_state", 64'(state), 64'(S_IF));
                    check("rm_late_ack_pc", 64'(pc), 64'(RST_PC));
                    @(posedge clk); #1;
                    return;
                end
                bus.data_ack = 1'b0;
                for (int i = 0; i <= dwait; i++) begin
                    if (i == dwait) begin
                        bus.data_ack = 1'b1;
                        bus.data_rdata = ldat;
                    end else begin
                        bus.data_rdata = $urandom;
                    end
                    @(negedge clk);
                    check("mem_state", 64'(state), 64'(S_MEM));
                    check("mem_req", 64'(bus.data_req), 64'd1);
                    check("mem_addr", 64'(bus.data_addr), 64'(alu));
                    check("mem_wdata", 64'(bus.data_wdata), 64'(sdat));
                    check("mem_we", 64'(bus.data_we), 64'(kind == K_ST));
                    check("mem_ir_hold", 64'(ir), 64'(word));
                    @(posedge clk); #1;
                end
                bus.data_ack = 1'b0;
            end
            if (kind != K_ST) begin
                @(negedge clk);
                check("wb_state", 64'(state), 64'(S_WB));
                check("wb_rf_we", 64'(rf_we), 64'd1);
                check("wb_pc_hold", 64'(pc), 64'(m_pc));
                check("wb_ir_hold", 64'(ir), 64'(word));
                @(posedge clk); #1;
            end
        end
        m_pc = taken ? target : m_pc + 32'd4;
        m_ret++;
        @(negedge clk);
        check("ret_state", 64'(state), 64'(S_IF));
        check("ret_pc", 64'(pc), 64'(m_pc));
        check("ret_inst_addr", 64'(bus.inst_addr), 64'(m_pc));
        check("retired", 64'(retired), 64'(m_ret % 16));
        check("ret_rf_we_low", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        bus.inst_ack = 1'b0;
        bus.inst_rdata = '0;
        bus.data_ack = 1'b0;
        bus.data_rdata = '0;
        dec_is_jump = 1'b0;
        dec_is_load = 1'b0;
        dec_is_store = 1'b0;
        br_taken = 1'b0;
        br_target = '0;
        alu_result = '0;
        store_data = '0;
        m_pc = RST_PC;
        m_ret = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(state), 64'(S_IF));
        check("rst_pc", 64'(pc), 64'(RST_PC));
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_ir", 64'(ir), 64'd0);
        check("rst_ireq", 64'(bus.inst_req), 64'd0);
        check("rst_dreq", 64'(bus.data_req), 64'd0);
        check("rst_dwe", 64'(bus.data_we), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_res", 64'(rf_wdata), 64'd0);
        check("rst_sd", 64'(bus.data_wdata), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(K_ALU, 1'b0, 32'h0, 32'h0000_0011, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        run_instr(K_JMP, 1'b1, 32'h1c00_0100, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        run_instr(K_LD, 1'b0, 32'h0, 32'h0000_0040, 32'h0, 32'hdead_beef, 1, 3, 1'b0, 1'b0);
        run_instr(K_ST, 1'b0, 32'h0, 32'h0000_0080, 32'h0000_1234, 32'h0, 0, 0, 1'b0, 1'b0);
        run_instr(K_ALU, 1'b0, 32'h0, 32'h5555_aaaa, 32'h0, 32'h0, 2, 0, 1'b1, 1'b0);
        run_instr(K_ALU, 1'b1, 32'h1c00_0200, 32'h0000_0007, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        run_instr(K_ST, 1'b1, 32'hffff_fffc, 32'h0000_0100, 32'hcafe_f00d, 32'h0, 0, 1, 1'b0, 1'b0);
        run_instr(K_JMP, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 3);
            run_instr(k, 1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, $urandom, $urandom,
                      $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end
        run_instr(K_ST, 1'b0, 32'h0, 32'h0000_0200, 32'h0000_beef, 32'h0, 0, 0, 1'b0, 1'b1);
        run_instr(K_ALU, 1'b0, 32'h0, 32'h0000_0abc, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0);

        check("rf_queue_drained", 64'(exp_q.size()), 64'd0);
        check("st_queue_drained", 64'(st_exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
